conv: RTL and testbench
=======================

CONV -- requirements
Module: conv

Interface
REQ-001 Parameter IFMAP_HEIGHT, default 128, input feature map rows.
REQ-002 Parameter IFMAP_WIDTH, default 128, input feature map columns.
REQ-003 Parameter KERNEL_HEIGHT, default 3, kernel rows.
REQ-004 Parameter KERNEL_WIDTH, default 3, kernel columns.
REQ-005 Parameter DATA_WIDTH, default 8, element width of ifmap, weights and ofmap.
REQ-006 Parameter H_STRIDE, default 1, horizontal stride.
REQ-007 Parameter V_STRIDE, default 1, vertical stride.
REQ-008 Parameter PADDING, default 0, zero-pad border width on all four sides.
REQ-009 Derived: OFMAP_HEIGHT = (IFMAP_HEIGHT+2*PADDING-KERNEL_HEIGHT)/V_STRIDE+1 and OFMAP_WIDTH = (IFMAP_WIDTH+2*PADDING-KERNEL_WIDTH)/H_STRIDE+1, integer division.
REQ-010 One clock; reset is asynchronous and active-low.
REQ-011 clk  input  1  rising-edge clock.
REQ-012 reset  input  1  asynchronous active-low reset.
REQ-013 en  input  1  start/run enable.
REQ-014 ifmap  input  unpacked [IFMAP_HEIGHT][IFMAP_WIDTH] of DATA_WIDTH unsigned  input feature map.
REQ-015 weights  input  unpacked [KERNEL_HEIGHT][KERNEL_WIDTH] of DATA_WIDTH signed  kernel.
REQ-016 ofmap  output  unpacked [OFMAP_HEIGHT][OFMAP_WIDTH] of DATA_WIDTH unsigned  registered output map.
REQ-017 done_conv  output  1  high while the full ofmap is valid.

Function
REQ-018 The FSM SHALL have the states IDLE, COMPUTE and DONE.
REQ-019 IDLE SHALL go to COMPUTE on a rising edge with en=1, with row counter r=0 and column counter c=0.
REQ-020 Each COMPUTE edge with en=1 SHALL write ofmap[r][c], then advance c, wrapping to 0 with r+1 after c=OFMAP_WIDTH-1.
REQ-021 Each pixel SHALL equal the sum over kh,kw of ifmap[r*V_STRIDE+kh-PADDING][c*H_STRIDE+kw-PADDING] * weights[kh][kw], with no kernel flip (cross-correlation).
REQ-022 An ifmap index falling in the padding region SHALL contribute 0.
REQ-023 Multiplication SHALL be unsigned ifmap (zero-extended) times signed weight, accumulated in a signed accumulator of at least 2*DATA_WIDTH+clog2(KERNEL_HEIGHT*KERNEL_WIDTH)+1 bits with no overflow.
REQ-024 The written pixel SHALL be the sum saturated to 0..2^DATA_WIDTH-1: sum<0 gives 0, sum>255 gives 255 (for 8-bit data).
REQ-025 The whole kernel window SHALL be computed combinationally within one cycle, giving one pixel per cycle.
REQ-026 Writing the last pixel (r=OFMAP_HEIGHT-1, c=OFMAP_WIDTH-1) SHALL move the FSM to DONE.
REQ-027 done_conv SHALL be 1 exactly while in DONE, first visible after the last pixel write.
REQ-028 Total latency SHALL be OFMAP_HEIGHT*OFMAP_WIDTH+1 rising edges from the edge that samples en=1 in IDLE (15877 for the defaults).
REQ-029 en=0 during COMPUTE SHALL pause the run: counters and ofmap hold, and the run resumes when en returns to 1.
REQ-030 DONE SHALL hold ofmap and done_conv while en=1.
REQ-031 en=0 in DONE SHALL return to IDLE, clear done_conv and keep ofmap contents.
REQ-032 ifmap and weights SHALL be sampled live each cycle; the user holds them stable from start until done_conv.
REQ-033 ofmap pixels not yet written in the current run SHALL retain their prior values.

Reset
REQ-034 reset=0 SHALL immediately force IDLE, r=c=0, done_conv=0 and every ofmap element to 0, regardless of clock.
REQ-035 Reset mid-COMPUTE SHALL abort the run; a new run starts from pixel (0,0) after reset=1 and en=1.
REQ-036 A rising edge coinciding with reset=0 SHALL perform no computation.

Verification
REQ-037 Defaults, ifmap all 10, kernel {0,-1,0;-1,4,-1;0,-1,0} -> every ofmap element 0; done_conv rises 15877 edges after start.
REQ-038 Zero ifmap except ifmap[5][5]=100, same Laplacian kernel -> ofmap[4][4]=255 (400 saturated); ofmap[3][4], [5][4], [4][3] and [4][5] are 0 (-100 clamped); all others 0.
REQ-039 Identity kernel (center 1, else 0), ifmap[i][j]=(i+j) mod 256 -> ofmap[i][j]=(i+j+2) mod 256 for all i,j.
REQ-040 PADDING=1 with the identity kernel -> ofmap is 128x128 and equals ifmap.
REQ-041 Pulse reset low after 500 COMPUTE cycles, then restart -> ofmap clears to 0 and done_conv=0; the rerun gives a full correct map with full latency.
REQ-042 Hold en=0 for 20 cycles mid-COMPUTE -> final ofmap unchanged, and done_conv is delayed by exactly 20 cycles.

Source files
------------

// File: rtl/conv.sv
// conv: direct 2-D cross-correlation of an unsigned feature map with a signed
// kernel. One output pixel per cycle is computed combinationally over the whole
// kernel window, saturated to the unsigned data range and stored into a
// registered output map. A small IDLE/COMPUTE/DONE FSM walks the output map in
// raster order.
module conv #(
    parameter int IFMAP_HEIGHT  = 128,
    parameter int IFMAP_WIDTH   = 128,
    parameter int KERNEL_HEIGHT = 3,
    parameter int KERNEL_WIDTH  = 3,
    parameter int DATA_WIDTH    = 8,
    parameter int H_STRIDE      = 1,
    parameter int V_STRIDE      = 1,
    parameter int PADDING       = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic        [DATA_WIDTH-1:0] ifmap   [IFMAP_HEIGHT][IFMAP_WIDTH],
    input  logic signed [DATA_WIDTH-1:0] weights [KERNEL_HEIGHT][KERNEL_WIDTH],
    output logic        [DATA_WIDTH-1:0] ofmap   [(IFMAP_HEIGHT+2*PADDING-KERNEL_HEIGHT)/V_STRIDE+1]
                                                 [(IFMAP_WIDTH+2*PADDING-KERNEL_WIDTH)/H_STRIDE+1],
    output logic                         done_conv
);

    localparam int OH    = (IFMAP_HEIGHT + 2*PADDING - KERNEL_HEIGHT) / V_STRIDE + 1;
    localparam int OW    = (IFMAP_WIDTH  + 2*PADDING - KERNEL_WIDTH)  / H_STRIDE + 1;
    localparam int RW    = (OH > 1) ? $clog2(OH) : 1;
    localparam int CW    = (OW > 1) ? $clog2(OW) : 1;
    localparam int IRW   = (IFMAP_HEIGHT > 1) ? $clog2(IFMAP_HEIGHT) : 1;
    localparam int ICW   = (IFMAP_WIDTH  > 1) ? $clog2(IFMAP_WIDTH)  : 1;
    // One guard bit beyond the worst-case product-sum growth
    localparam int ACC_W = 2*DATA_WIDTH + $clog2(KERNEL_HEIGHT*KERNEL_WIDTH) + 2;

    localparam logic [RW-1:0] R_LAST = RW'(OH - 1);
    localparam logic [CW-1:0] C_LAST = CW'(OW - 1);
    localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((1 << DATA_WIDTH) - 1);

    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

    state_t                  state_q;
    logic [RW-1:0]           r_q;
    logic [CW-1:0]           c_q;
    logic                    done_q;

    logic signed [31:0]      r_ext;
    logic signed [31:0]      c_ext;
    logic signed [ACC_W-1:0] prod_w [KERNEL_HEIGHT][KERNEL_WIDTH];
    logic signed [ACC_W-1:0] acc_sum;
    logic [DATA_WIDTH-1:0]   pix_d;

    assign r_ext     = 32'(r_q);
    assign c_ext     = 32'(c_q);
    assign done_conv = done_q;

    // One multiplier per kernel tap; taps landing in the zero-pad border give 0
    genvar gi, gj;
    generate
        for (gi = 0; gi < KERNEL_HEIGHT; gi++) begin : g_row
            for (gj = 0; gj < KERNEL_WIDTH; gj++) begin : g_col
                logic signed [31:0]      row_s;
                logic signed [31:0]      col_s;
                logic                    in_rng;
                logic [IRW-1:0]          row_idx;
                logic [ICW-1:0]          col_idx;
                logic signed [ACC_W-1:0] px_ext;
                logic signed [ACC_W-1:0] wt_ext;

                assign row_s   = r_ext * V_STRIDE + gi - PADDING;
                assign col_s   = c_ext * H_STRIDE + gj - PADDING;
                assign in_rng  = (row_s >= 0) && (row_s < IFMAP_HEIGHT) &&
                                 (col_s >= 0) && (col_s < IFMAP_WIDTH);
                // Clamp the index so an out-of-window tap never addresses past the array
                assign row_idx = in_rng ? row_s[IRW-1:0] : '0;
                assign col_idx = in_rng ? col_s[ICW-1:0] : '0;
                assign px_ext  = $signed({{(ACC_W-DATA_WIDTH){1'b0}}, ifmap[row_idx][col_idx]});
                assign wt_ext  = ACC_W'(weights[gi][gj]);
                assign prod_w[gi][gj] = in_rng ? (px_ext * wt_ext) : '0;
            end
        end
    endgenerate

    // Sum every tap of the window for the current (r, c)
    always_comb begin
        acc_sum = '0;
        for (int i = 0; i < KERNEL_HEIGHT; i++) begin
            for (int j = 0; j < KERNEL_WIDTH; j++) begin
                acc_sum = acc_sum + prod_w[i][j];
            end
        end
    end

    // Clamp the signed sum into the unsigned pixel range
    always_comb begin
        if (acc_sum < 0) begin
            pix_d = '0;
        end else if (acc_sum > PIX_MAX) begin
            pix_d = '1;
        end else begin
            pix_d = acc_sum[DATA_WIDTH-1:0];
        end
    end

    // Control FSM, raster counters, output map and done flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            r_q     <= '0;
            c_q     <= '0;
            done_q  <= 1'b0;
            for (int i = 0; i < OH; i++) begin
                for (int j = 0; j < OW; j++) begin
                    ofmap[i][j] <= '0;
                end
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (en) begin
                        state_q <= COMPUTE;
                        r_q     <= '0;
                        c_q     <= '0;
                    end
                end
                COMPUTE: begin
                    if (en) begin
                        ofmap[r_q][c_q] <= pix_d;
                        if (c_q == C_LAST) begin
                            c_q <= '0;
                            if (r_q == R_LAST) begin
                                state_q <= DONE;
                                done_q  <= 1'b1;
                            end else begin
                                r_q <= r_q + RW'(1);
                            end
                        end else begin
                            c_q <= c_q + CW'(1);
                        end
                    end
                end
                DONE: begin
                    if (!en) begin
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv.sv
// tb_conv: scoreboard bench for conv. Instance A is a small unpadded 3x3
// configuration; instance B adds padding and a horizontal stride of 2.
// Expected maps are pushed when stimulus is set up and popped by a monitor
// when done_conv rises.
module tb_conv;

    localparam int A_IH = 12, A_IW = 10, A_PAD = 0, A_HS = 1, A_VS = 1;
    localparam int A_OH = (A_IH + 2*A_PAD - 3) / A_VS + 1;
    localparam int A_OW = (A_IW + 2*A_PAD - 3) / A_HS + 1;
    localparam int LAT_A = A_OH * A_OW + 1;

    localparam int B_IH = 9, B_IW = 11, B_PAD = 1, B_HS = 2, B_VS = 1;
    localparam int B_OH = (B_IH + 2*B_PAD - 3) / B_VS + 1;
    localparam int B_OW = (B_IW + 2*B_PAD - 3) / B_HS + 1;
    localparam int LAT_B = B_OH * B_OW + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en_a = 1'b0;
    logic en_b = 1'b0;

    logic        [7:0] if_a [A_IH][A_IW];
    logic signed [7:0] w_a  [3][3];
    logic        [7:0] of_a [A_OH][A_OW];
    logic              done_a;

    logic        [7:0] if_b [B_IH][B_IW];
    logic signed [7:0] w_b  [3][3];
    logic        [7:0] of_b [B_OH][B_OW];
    logic              done_b;

    logic [7:0] sb_a [$];
    logic [7:0] sb_b [$];
    logic [7:0] exp_map_a [A_OH][A_OW];

    int n_checks = 0;
    int n_errors = 0;
    logic prev_done_a = 1'b0;
    logic prev_done_b = 1'b0;

    always #5 clk = ~clk;

    conv #(.IFMAP_HEIGHT(A_IH), .IFMAP_WIDTH(A_IW), .KERNEL_HEIGHT(3), .KERNEL_WIDTH(3),
           .DATA_WIDTH(8), .H_STRIDE(A_HS), .V_STRIDE(A_VS), .PADDING(A_PAD)) u_a (
        .clk(clk), .reset(rst_n), .en(en_a), .ifmap(if_a), .weights(w_a),
        .ofmap(of_a), .done_conv(done_a));

    conv #(.IFMAP_HEIGHT(B_IH), .IFMAP_WIDTH(B_IW), .KERNEL_HEIGHT(3), .KERNEL_WIDTH(3),
           .DATA_WIDTH(8), .H_STRIDE(B_HS), .V_STRIDE(B_VS), .PADDING(B_PAD)) u_b (
        .clk(clk), .reset(rst_n), .en(en_b), .ifmap(if_b), .weights(w_b),
        .ofmap(of_b), .done_conv(done_b));

    // Reference cross-correlation for instance A, pushed into the scoreboard
    task automatic push_a();
        int s, row, col;
        for (int r = 0; r < A_OH; r++) begin
            for (int c = 0; c < A_OW; c++) begin
                s = 0;
                for (int kh = 0; kh < 3; kh++) begin
                    for (int kw = 0; kw < 3; kw++) begin
                        row = r*A_VS + kh - A_PAD;
                        col = c*A_HS + kw - A_PAD;
                        if (row >= 0 && row < A_IH && col >= 0 && col < A_IW)
                            s += int'(if_a[row][col]) * int'(w_a[kh][kw]);
                    end
                end
                if (s < 0) s = 0;
                if (s > 255) s = 255;
                exp_map_a[r][c] = 8'(s);
                sb_a.push_back(8'(s));
            end
        end
    endtask

    // Reference cross-correlation for instance B (padded, strided)
    task automatic push_b();
        int s, row, col;
        for (int r = 0; r < B_OH; r++) begin
            for (int c = 0; c < B_OW; c++) begin
                s = 0;
                for (int kh = 0; kh < 3; kh++) begin
                    for (int kw = 0; kw < 3; kw++) begin
                        row = r*B_VS + kh - B_PAD;
                        col = c*B_HS + kw - B_PAD;
                        if (row >= 0 && row < B_IH && col >= 0 && col < B_IW)
                            s += int'(if_b[row][col]) * int'(w_b[kh][kw]);
                    end
                end
                if (s < 0) s = 0;
                if (s > 255) s = 255;
                sb_b.push_back(8'(s));
            end
        end
    endtask

    // Scoreboard consumer for A: compare whole map when done_conv rises
    always begin : mon_a
        logic [7:0] e;
        @(posedge clk);
        #1;
        if (done_a && !prev_done_a) begin
            for (int i = 0; i < A_OH; i++) begin
                for (int j = 0; j < A_OW; j++) begin
                    n_checks++;
                    if (sb_a.size() == 0) begin
                        n_errors++;
                        $display("FAIL sb_a_underflow: pixel [%0d][%0d]=%0d with no expected value", i, j, of_a[i][j]);
                    end else begin
                        e = sb_a.pop_front();
                        if (of_a[i][j] !== e) begin
                            n_errors++;
                            $display("FAIL ofmap_a[%0d][%0d]: got %0d, expected %0d", i, j, of_a[i][j], e);
                        end
                    end
                end
            end
        end
        prev_done_a = done_a;
    end

    // Scoreboard consumer for B
    always begin : mon_b
        logic [7:0] e;
        @(posedge clk);
        #1;
        if (done_b && !prev_done_b) begin
            for (int i = 0; i < B_OH; i++) begin
                for (int j = 0; j < B_OW; j++) begin
                    n_checks++;
                    if (sb_b.size() == 0) begin
                        n_errors++;
                        $display("FAIL sb_b_underflow: pixel [%0d][%0d]=%0d with no expected value", i, j, of_b[i][j]);
                    end else begin
                        e = sb_b.pop_front();
                        if (of_b[i][j] !== e) begin
                            n_errors++;
                            $display("FAIL ofmap_b[%0d][%0d]: got %0d, expected %0d", i, j, of_b[i][j], e);
                        end
                    end
                end
            end
        end
        prev_done_b = done_b;
    end

    // Start a run on A, optionally pausing, and count edges until done_conv
    task automatic run_a(input int pause_at, input int pause_len, output int edges);
        int n;
        bit seen;
        n = 0;
        seen = 0;
        @(negedge clk);
        en_a = 1'b1;
        while (!seen && n < 2000) begin
            @(posedge clk);
            n++;
            #1;
            if (done_a) begin
                seen = 1;
            end else if (n == pause_at) begin
                en_a = 1'b0;
                repeat (pause_len) begin
                    @(posedge clk);
                    n++;
                end
                #1;
                en_a = 1'b1;
            end
        end
        edges = n;
    endtask

    task automatic idle_a();
        @(negedge clk);
        en_a = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int bad;
        en_a = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (done_a !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_done: got %b, expected 0", done_a);
        end
        bad = 0;
        for (int i = 0; i < A_OH; i++)
            for (int j = 0; j < A_OW; j++)
                if (of_a[i][j] !== 8'd0) bad++;
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL reset_map: %0d nonzero pixels, expected 0", bad);
        end
        @(negedge clk);
        en_a = 1'b0;
        rst_n = 1'b1;
        $display("test_reset: done");
    endtask

    task automatic test_flat();
        int e;
        for (int i = 0; i < A_IH; i++)
            for (int j = 0; j < A_IW; j++)
                if_a[i][j] = 8'd10;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w_a[i][j] = (i == 1 && j == 1) ? 8'sd4 : ((i == 1 || j == 1) ? -8'sd1 : 8'sd0);
        push_a();
        run_a(0, 0, e);
        n_checks++;
        if (e != LAT_A) begin
            n_errors++;
            $display("FAIL latency_flat: got %0d edges, expected %0d", e, LAT_A);
        end
        $display("test_flat: latency %0d", e);
    endtask

    task automatic test_done_hold();
        int bad;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (done_a !== 1'b1) begin
            n_errors++;
            $display("FAIL done_hold: got %b, expected 1", done_a);
        end
        idle_a();
        n_checks++;
        if (done_a !== 1'b0) begin
            n_errors++;
            $display("FAIL done_clear: got %b, expected 0", done_a);
        end
        bad = 0;
        for (int i = 0; i < A_OH; i++)
            for (int j = 0; j < A_OW; j++)
                if (of_a[i][j] !== exp_map_a[i][j]) bad++;
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL idle_keeps_map: %0d pixels changed, expected 0", bad);
        end
        $display("test_done_hold: done");
    endtask

    task automatic test_impulse();
        int e;
        for (int i = 0; i < A_IH; i++)
            for (int j = 0; j < A_IW; j++)
                if_a[i][j] = 8'd0;
        if_a[5][5] = 8'd100;
        push_a();
        run_a(0, 0, e);
        n_checks++;
        if (of_a[4][4] !== 8'd255) begin
            n_errors++;
            $display("FAIL impulse_center: got %0d, expected 255", of_a[4][4]);
        end
        n_checks++;
        if (of_a[3][4] !== 8'd0 || of_a[4][5] !== 8'd0) begin
            n_errors++;
            $display("FAIL impulse_neighbor: got %0d/%0d, expected 0/0", of_a[3][4], of_a[4][5]);
        end
        idle_a();
        $display("test_impulse: latency %0d", e);
    endtask

    task automatic test_identity();
        int e;
        for (int i = 0; i < A_IH; i++)
            for (int j = 0; j < A_IW; j++)
                if_a[i][j] = 8'((i*37 + j*11 + 200) % 256);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w_a[i][j] = (i == 1 && j == 1) ? 8'sd1 : 8'sd0;
        push_a();
        run_a(0, 0, e);
        n_checks++;
        if (of_a[A_OH-1][A_OW-1] !== if_a[A_OH][A_OW]) begin
            n_errors++;
            $display("FAIL identity_last: got %0d, expected %0d", of_a[A_OH-1][A_OW-1], if_a[A_OH][A_OW]);
        end
        idle_a();
        $display("test_identity: latency %0d", e);
    endtask

    task automatic test_random_sat();
        int e;
        for (int i = 0; i < A_IH; i++)
            for (int j = 0; j < A_IW; j++)
                if_a[i][j] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w_a[i][j] = 8'($urandom_range(0, 6)) - 8'd3;
        w_a[0][0] = -8'sd128;
        w_a[2][2] = 8'sd127;
        push_a();
        run_a(0, 0, e);
        n_checks++;
        if (e != LAT_A) begin
            n_errors++;
            $display("FAIL latency_random: got %0d edges, expected %0d", e, LAT_A);
        end
        idle_a();
        $display("test_random_sat: latency %0d", e);
    endtask

    task automatic test_pause();
        int e;
        for (int i = 0; i < A_IH; i++)
            for (int j = 0; j < A_IW; j++)
                if_a[i][j] = 8'($urandom_range(0, 60));
        push_a();
        run_a(30, 20, e);
        n_checks++;
        if (e != LAT_A + 20) begin
            n_errors++;
            $display("FAIL latency_pause: got %0d edges, expected %0d", e, LAT_A + 20);
        end
        idle_a();
        $display("test_pause: latency %0d", e);
    endtask

    task automatic test_retain();
        logic [7:0] old_map [A_OH][A_OW];
        int bad, n;
        old_map = exp_map_a;
        for (int i = 0; i < A_IH; i++)
            for (int j = 0; j < A_IW; j++)
                if_a[i][j] = 8'($urandom_range(100, 255));
        push_a();
        @(negedge clk);
        en_a = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        // Start edge plus nine writes: pixels 0..8 are new, the rest untouched
        bad = 0;
        for (int k = 9; k < A_OH*A_OW; k++)
            if (of_a[k / A_OW][k % A_OW] !== old_map[k / A_OW][k % A_OW]) bad++;
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL retain_unwritten: %0d pixels changed early, expected 0", bad);
        end
        n = 10;
        while (!done_a && n < 2000) begin
            @(posedge clk);
            n++;
            #1;
        end
        n_checks++;
        if (n != LAT_A) begin
            n_errors++;
            $display("FAIL latency_retain: got %0d edges, expected %0d", n, LAT_A);
        end
        idle_a();
        $display("test_retain: latency %0d", n);
    endtask

    task automatic test_abort();
        int e, bad;
        for (int i = 0; i < A_IH; i++)
            for (int j = 0; j < A_IW; j++)
                if_a[i][j] = 8'($urandom_range(0, 255));
        push_a();
        @(negedge clk);
        en_a = 1'b1;
        repeat (40) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        bad = 0;
        for (int i = 0; i < A_OH; i++)
            for (int j = 0; j < A_OW; j++)
                if (of_a[i][j] !== 8'd0) bad++;
        n_checks++;
        if (bad != 0 || done_a !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_clear: %0d nonzero pixels done=%b, expected 0 and 0", bad, done_a);
        end
        sb_a.delete();
        repeat (2) @(posedge clk);
        #1;
        bad = 0;
        for (int i = 0; i < A_OH; i++)
            for (int j = 0; j < A_OW; j++)
                if (of_a[i][j] !== 8'd0) bad++;
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL reset_no_compute: %0d nonzero pixels, expected 0", bad);
        end
        @(negedge clk);
        en_a = 1'b0;
        rst_n = 1'b1;
        push_a();
        run_a(0, 0, e);
        n_checks++;
        if (e != LAT_A) begin
            n_errors++;
            $display("FAIL latency_rerun: got %0d edges, expected %0d", e, LAT_A);
        end
        idle_a();
        $display("test_abort: rerun latency %0d", e);
    endtask

    task automatic test_pad_stride();
        int n;
        for (int i = 0; i < B_IH; i++)
            for (int j = 0; j < B_IW; j++)
                if_b[i][j] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w_b[i][j] = 8'($urandom_range(0, 4)) - 8'd2;
        push_b();
        @(negedge clk);
        en_b = 1'b1;
        n = 0;
        while (!done_b && n < 2000) begin
            @(posedge clk);
            n++;
            #1;
        end
        n_checks++;
        if (n != LAT_B) begin
            n_errors++;
            $display("FAIL latency_pad_stride: got %0d edges, expected %0d", n, LAT_B);
        end
        @(negedge clk);
        en_b = 1'b0;
        @(posedge clk);
        #1;
        $display("test_pad_stride: latency %0d", n);
    endtask

    initial begin
        for (int i = 0; i < A_IH; i++)
            for (int j = 0; j < A_IW; j++)
                if_a[i][j] = 8'd0;
        for (int i = 0; i < B_IH; i++)
            for (int j = 0; j < B_IW; j++)
                if_b[i][j] = 8'd0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                w_a[i][j] = 8'sd0;
                w_b[i][j] = 8'sd0;
            end
        test_reset();
        test_flat();
        test_done_hold();
        test_impulse();
        test_identity();
        test_random_sat();
        test_pause();
        test_retain();
        test_abort();
        test_pad_stride();
        n_checks++;
        if (sb_a.size() != 0 || sb_b.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_leftover: %0d/%0d entries left, expected 0/0", sb_a.size(), sb_b.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
